// File: rtl/uart_rx_fsm_pkg.sv
// rtl/uart_rx_fsm_pkg.sv - shared UART state codes, line levels and parity helper
package uart_rx_fsm_pkg;

  localparam int DATA_BITS = 8;

  // State codes are shared with the TX FSM so debug displays read the same way
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START_BIT  = 3'd1;
  localparam logic [2:0] ST_RX_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY_BIT = 3'd3;
  localparam logic [2:0] ST_STOP_BIT   = 3'd4;
  localparam logic [2:0] ST_RX_DONE    = 3'd5;

  // Serial line levels
  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam logic TX_START_LVL = 1'b0;
  localparam logic TX_STOP_LVL  = 1'b1;

  // Parity bit a transmitter would send for this byte
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit timer with mid-bit and end-of-bit ticks
module uart_bit_timer #(
  parameter int BIT_TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int W = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
  localparam logic [W-1:0] LAST      = W'(BIT_TICKS - 1);
  localparam logic [W-1:0] HALF_LAST = W'(BIT_TICKS / 2 - 1);

  logic [W-1:0] cnt;

  // Count 0..BIT_TICKS-1 while enabled; clear has priority so sample points restart the bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver: 8 data bits LSB first, one parity bit, one stop bit
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy,
  output logic [2:0]           rx_state_out
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [3:0]           bit_cnt;
  logic                 parity_bad;
  logic                 stop_bad;
  logic                 half_tick;
  logic                 full_tick;
  logic                 timer_en;
  logic                 timer_clr;
  logic                 sample;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= TX_IDLE_LVL;
      rx_s    <= TX_IDLE_LVL;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Start bit is checked at its middle; every later bit is sampled one full bit after that
  always_comb begin
    sample = 1'b0;
    case (state)
      ST_START_BIT:                           sample = half_tick;
      ST_RX_DATA, ST_PARITY_BIT, ST_STOP_BIT: sample = full_tick;
      default:                                sample = 1'b0;
    endcase
  end

  // Holding the timer clear in IDLE gives a zero count on entry to START_BIT
  assign timer_en  = (state != ST_IDLE) && (state != ST_RX_DONE);
  assign timer_clr = (state == ST_IDLE) || sample;

  uart_bit_timer #(
    .BIT_TICKS(BIT_TICKS)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (timer_en),
    .clr      (timer_clr),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // Next-state logic; unused codes fall back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (rx_s == TX_START_LVL) state_nxt = ST_START_BIT;
      ST_START_BIT:  if (sample) state_nxt = (rx_s == TX_START_LVL) ? ST_RX_DATA : ST_IDLE;
      ST_RX_DATA:    if (sample && bit_cnt == LAST_BIT) state_nxt = ST_PARITY_BIT;
      ST_PARITY_BIT: if (sample) state_nxt = ST_STOP_BIT;
      ST_STOP_BIT:   if (sample) state_nxt = ST_RX_DONE;
      ST_RX_DONE:    state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Shift in data LSB first and capture per-frame error conditions at their sample points
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bad <= 1'b0;
      stop_bad   <= 1'b0;
    end else if (sample) begin
      case (state)
        ST_START_BIT: bit_cnt <= '0;
        ST_RX_DATA: begin
          shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_cnt   <= bit_cnt + 1'b1;
        end
        ST_PARITY_BIT: parity_bad <= (rx_s != parity_of(shift_reg, PARITY_ODD));
        ST_STOP_BIT:   stop_bad   <= (rx_s != TX_STOP_LVL);
        default: ;
      endcase
    end
  end

  // Publish the frame from RX_DONE; data and flags hold until the next frame completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= (state == ST_RX_DONE);
      if (state == ST_RX_DONE) begin
        rx_data    <= shift_reg;
        parity_err <= parity_bad;
        frame_err  <= stop_bad;
      end
    end
  end

  assign rx_busy      = (state != ST_IDLE);
  assign rx_state_out = state;

endmodule
